// File: rtl/ball_physics_engine_if.sv
// Collision-map read bus: engine issues an address/strobe, map answers with wall flags one cycle later.
interface ball_physics_engine_if;
  logic [18:0] coll_addr;
  logic        coll_rd;
  logic        coll_x_hit;
  logic        coll_y_hit;

  modport master (output coll_addr, coll_rd, input  coll_x_hit, coll_y_hit);
  modport slave  (input  coll_addr, coll_rd, output coll_x_hit, coll_y_hit);
endinterface

// File: rtl/ball_physics_engine.sv
// Per-frame ball physics: reflect, move, thrust, decel and clamp for N_BALLS balls, published atomically.
// Optional feature macro: OVERRUN_CNT_EN adds a saturating count of ignored frame ticks.
module ball_physics_engine #(
  parameter int unsigned N_BALLS          = 4,
  parameter int unsigned H_RES            = 800,
  parameter int unsigned V_RES            = 600,
  parameter int unsigned MAX_SPEED        = 20,
  parameter int unsigned DECEL            = 1,
  parameter int unsigned FRAMES_PER_DECEL = 5,
  parameter int unsigned INIT_X           = 200,
  parameter int unsigned INIT_Y           = 300,
  parameter int unsigned INIT_STEP        = 40
) (
  input  logic                         pixel_clk,
  input  logic                         rst_n,
  input  logic                         frame_tick,
  input  logic [2:0]                   sel_ball,
  input  logic                         thrust_l,
  input  logic                         thrust_r,
  input  logic                         thrust_u,
  input  logic                         thrust_d,
  ball_physics_engine_if.master        coll,
  output logic [N_BALLS*10-1:0]        ball_x,
  output logic [N_BALLS*10-1:0]        ball_y,
  output logic [N_BALLS*10-1:0]        speed_x,
  output logic [N_BALLS*10-1:0]        speed_y,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun
`ifdef OVERRUN_CNT_EN
  ,
  output logic [7:0]                   overrun_cnt
`endif
);

  localparam int unsigned PW    = 10;
  localparam int unsigned AW    = 19;
  localparam int unsigned IDX_W = (N_BALLS > 1) ? $clog2(N_BALLS) : 1;
  localparam int unsigned FC_W  = (FRAMES_PER_DECEL > 1) ? $clog2(FRAMES_PER_DECEL) : 1;

  localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N_BALLS - 1);
  localparam logic [FC_W-1:0]         FC_LAST  = FC_W'(FRAMES_PER_DECEL - 1);
  localparam logic signed [PW:0]      X_LIM    = (PW+1)'(H_RES - 1);
  localparam logic signed [PW:0]      Y_LIM    = (PW+1)'(V_RES - 1);
  localparam logic signed [PW-1:0]    VMAX     = PW'(MAX_SPEED);
  localparam logic signed [PW-1:0]    DEC      = PW'(DECEL);

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, UPD, PUB} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FC_W-1:0]       fcnt_q;
  logic                  decel_q;
  logic [2:0]            sel_q;
  logic signed [PW-1:0]  thr_x_q, thr_y_q;
  logic                  hit_x_q, hit_y_q;

  logic [PW-1:0]         wx  [N_BALLS];
  logic [PW-1:0]         wy  [N_BALLS];
  logic signed [PW-1:0]  wvx [N_BALLS];
  logic signed [PW-1:0]  wvy [N_BALLS];

  logic                  accept, tick_busy;
  logic                  busy_d, done_d, coll_rd_d;
  logic [AW-1:0]         coll_addr_d;

  logic [PW-1:0]         cur_x, cur_y, nx, ny;
  logic signed [PW-1:0]  cur_vx, cur_vy, vx_r, vy_r, vx_t, vy_t, nvx, nvy;
  logic signed [PW-1:0]  thr_x_d, thr_y_d;

  function automatic logic [PW-1:0] sat_pos(input logic [PW-1:0] p, input logic signed [PW-1:0] v,
                                            input logic signed [PW:0] lim);
    logic signed [PW:0] s;
    s = $signed({1'b0, p}) + $signed({v[PW-1], v});
    if (s < 11'sd0)    return '0;
    else if (s > lim)  return lim[PW-1:0];
    else               return s[PW-1:0];
  endfunction

  function automatic logic signed [PW-1:0] decel_v(input logic signed [PW-1:0] v);
    if (v <= DEC && v >= -DEC) return '0;
    else if (v > 10'sd0)       return v - DEC;
    else                       return v + DEC;
  endfunction

  function automatic logic signed [PW-1:0] clamp_v(input logic signed [PW-1:0] v);
    if (v > VMAX)       return VMAX;
    else if (v < -VMAX) return -VMAX;
    else                return v;
  endfunction

  // Opposite buttons cancel; encoded as a signed step per axis.
  always_comb begin
    thr_x_d = 10'sd0;
    thr_y_d = 10'sd0;
    if (thrust_r && !thrust_l) thr_x_d = 10'sd1;
    if (thrust_l && !thrust_r) thr_x_d = -10'sd1;
    if (thrust_d && !thrust_u) thr_y_d = 10'sd1;
    if (thrust_u && !thrust_d) thr_y_d = -10'sd1;
  end

  // FSM state register
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FSM next-state and next-cycle output values
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    accept      = 1'b0;
    tick_busy   = 1'b0;
    coll_addr_d = '0;
    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          accept  = 1'b1;
          state_d = ADDR;
          idx_d   = '0;
        end
      end
      ADDR: state_d = WAIT;
      WAIT: state_d = UPD;
      UPD: begin
        if (idx_q == LAST_IDX) begin
          state_d = PUB;
        end else begin
          state_d = ADDR;
          idx_d   = idx_q + 1'b1;
        end
      end
      PUB:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && frame_tick) tick_busy = 1'b1;
    busy_d    = (state_d != IDLE);
    done_d    = (state_q == PUB);
    coll_rd_d = (state_d == ADDR);
    if (state_d == ADDR) coll_addr_d = AW'(wy[idx_d]) * AW'(H_RES) + AW'(wx[idx_d]);
  end

  // Per-ball update for the ball at idx_q, using hit flags captured in WAIT.
  always_comb begin
    cur_x  = wx[idx_q];
    cur_y  = wy[idx_q];
    cur_vx = wvx[idx_q];
    cur_vy = wvy[idx_q];
    vx_r   = hit_x_q ? -cur_vx : cur_vx;
    vy_r   = hit_y_q ? -cur_vy : cur_vy;
    nx     = sat_pos(cur_x, vx_r, X_LIM);
    ny     = sat_pos(cur_y, vy_r, Y_LIM);
    vx_t   = vx_r;
    vy_t   = vy_r;
    if (3'(idx_q) == sel_q) begin
      vx_t = vx_r + thr_x_q;
      vy_t = vy_r + thr_y_q;
    end
    if (decel_q) begin
      vx_t = decel_v(vx_t);
      vy_t = decel_v(vy_t);
    end
    nvx = clamp_v(vx_t);
    nvy = clamp_v(vy_t);
  end

  // Datapath, working copy and published copy
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q         <= '0;
      decel_q        <= 1'b0;
      sel_q          <= '0;
      thr_x_q        <= '0;
      thr_y_q        <= '0;
      hit_x_q        <= 1'b0;
      hit_y_q        <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      overrun        <= 1'b0;
      coll.coll_rd   <= 1'b0;
      coll.coll_addr <= '0;
      for (int unsigned i = 0; i < N_BALLS; i++) begin
        wx[i]                <= PW'(INIT_X + i * INIT_STEP);
        wy[i]                <= PW'(INIT_Y);
        wvx[i]               <= '0;
        wvy[i]               <= '0;
        ball_x[PW*i +: PW]   <= PW'(INIT_X + i * INIT_STEP);
        ball_y[PW*i +: PW]   <= PW'(INIT_Y);
        speed_x[PW*i +: PW]  <= '0;
        speed_y[PW*i +: PW]  <= '0;
      end
    end else begin
      busy           <= busy_d;
      done           <= done_d;
      coll.coll_rd   <= coll_rd_d;
      coll.coll_addr <= coll_addr_d;
      if (accept) begin
        fcnt_q  <= (fcnt_q == FC_LAST) ? '0 : fcnt_q + 1'b1;
        decel_q <= (fcnt_q == '0);
        sel_q   <= sel_ball;
        thr_x_q <= thr_x_d;
        thr_y_q <= thr_y_d;
      end
      if (tick_busy) overrun <= 1'b1;
      if (state_q == WAIT) begin
        hit_x_q <= coll.coll_x_hit;
        hit_y_q <= coll.coll_y_hit;
      end
      if (state_q == UPD) begin
        wx[idx_q]  <= nx;
        wy[idx_q]  <= ny;
        wvx[idx_q] <= nvx;
        wvy[idx_q] <= nvy;
      end
      if (state_q == PUB) begin
        for (int unsigned i = 0; i < N_BALLS; i++) begin
          ball_x[PW*i +: PW]  <= wx[i];
          ball_y[PW*i +: PW]  <= wy[i];
          speed_x[PW*i +: PW] <= wvx[i];
          speed_y[PW*i +: PW] <= wvy[i];
        end
      end
    end
  end

`ifdef OVERRUN_CNT_EN
  // Saturating count of ticks dropped while a pass was running
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n)                                  overrun_cnt <= '0;
    else if (tick_busy && overrun_cnt != 8'hFF)  overrun_cnt <= overrun_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_ball_physics_engine.sv
// Scoreboard bench for ball_physics_engine: a behavioural model queues expected frames, a monitor checks each done.
module tb_ball_physics_engine;
  localparam int N = 4;

  typedef struct packed {
    logic [N*10-1:0] x;
    logic [N*10-1:0] y;
    logic [N*10-1:0] vx;
    logic [N*10-1:0] vy;
    logic [31:0]     cyc;
  } exp_t;

  logic            pixel_clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            frame_tick = 1'b0;
  logic [2:0]      sel_ball = '0;
  logic            thrust_l = 1'b0, thrust_r = 1'b0, thrust_u = 1'b0, thrust_d = 1'b0;
  logic [N*10-1:0] ball_x, ball_y, speed_x, speed_y;
  logic            busy, done, overrun;
`ifdef OVERRUN_CNT_EN
  logic [7:0]      overrun_cnt;
`endif

  ball_physics_engine_if coll ();

  ball_physics_engine dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .sel_ball  (sel_ball),
    .thrust_l  (thrust_l),
    .thrust_r  (thrust_r),
    .thrust_u  (thrust_u),
    .thrust_d  (thrust_d),
    .coll      (coll.master),
    .ball_x    (ball_x),
    .ball_y    (ball_y),
    .speed_x   (speed_x),
    .speed_y   (speed_y),
    .busy      (busy),
    .done      (done),
    .overrun   (overrun)
`ifdef OVERRUN_CNT_EN
    ,
    .overrun_cnt(overrun_cnt)
`endif
  );

  always #5 pixel_clk = ~pixel_clk;

  int cyc = 0;
  always @(posedge pixel_clk) cyc <= cyc + 1;

  // Collision map: one wall cell per axis, answered one cycle after the read strobe.
  logic [18:0] hit_x_addr = '1;
  logic [18:0] hit_y_addr = '1;
  always @(posedge pixel_clk) begin
    coll.coll_x_hit <= coll.coll_rd && (coll.coll_addr == hit_x_addr);
    coll.coll_y_hit <= coll.coll_rd && (coll.coll_addr == hit_y_addr);
  end

  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;
  exp_t sb[$];
  int   mx[N], my[N], mvx[N], mvy[N];
  int   mfc;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = 200 + 40 * i;
      my[i] = 300;
      mvx[i] = 0;
      mvy[i] = 0;
    end
    mfc = 0;
  endtask

  function automatic int slow(input int v);
    if (v > 1) return v - 1;
    if (v < -1) return v + 1;
    return 0;
  endfunction

  function automatic int limit(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic model_pass(input int sel, input bit l, input bit r, input bit u, input bit d);
    bit   dec;
    int   addr;
    exp_t e;
    dec = (mfc == 0);
    mfc = (mfc + 1) % 5;
    for (int i = 0; i < N; i++) begin
      addr = my[i] * 800 + mx[i];
      if (addr == int'(hit_x_addr)) mvx[i] = -mvx[i];
      if (addr == int'(hit_y_addr)) mvy[i] = -mvy[i];
      mx[i] = limit(mx[i] + mvx[i], 0, 799);
      my[i] = limit(my[i] + mvy[i], 0, 599);
      if (i == sel) begin
        mvx[i] = mvx[i] + int'(r) - int'(l);
        mvy[i] = mvy[i] + int'(d) - int'(u);
      end
      if (dec) begin
        mvx[i] = slow(mvx[i]);
        mvy[i] = slow(mvy[i]);
      end
      mvx[i] = limit(mvx[i], -20, 20);
      mvy[i] = limit(mvy[i], -20, 20);
      e.x[10*i +: 10]  = 10'(mx[i]);
      e.y[10*i +: 10]  = 10'(my[i]);
      e.vx[10*i +: 10] = 10'(mvx[i]);
      e.vy[10*i +: 10] = 10'(mvy[i]);
    end
    e.cyc = 32'(cyc);
    sb.push_back(e);
  endtask

  // Raise the tick for one cycle; buttons are released right after the accepting edge.
  task automatic tick(input int sel, input bit l, input bit r, input bit u, input bit d);
    @(negedge pixel_clk);
    sel_ball = 3'(sel);
    {thrust_l, thrust_r, thrust_u, thrust_d} = {l, r, u, d};
    frame_tick = 1'b1;
    @(negedge pixel_clk);
    frame_tick = 1'b0;
    {thrust_l, thrust_r, thrust_u, thrust_d} = 4'b0;
    model_pass(sel, l, r, u, d);
  endtask

  task automatic wait_quiet();
    for (int k = 0; k < 60; k++) begin
      @(negedge pixel_clk);
      if (!busy && sb.size() == 0) return;
    end
    chk("pass_timeout", 1, 0);
    sb.delete();
  endtask

  task automatic frame(input int sel, input bit l, input bit r, input bit u, input bit d);
    tick(sel, l, r, u, d);
    wait_quiet();
  endtask

  task automatic do_reset();
    @(negedge pixel_clk);
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    repeat (2) @(negedge pixel_clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_overrun"}, overrun, 0);
    chk({tag, "_coll_rd"}, coll.coll_rd, 0);
    chk({tag, "_coll_addr"}, coll.coll_addr, 0);
    chk({tag, "_ball_x"}, ball_x, {10'd320, 10'd280, 10'd240, 10'd200});
    chk({tag, "_ball_y"}, ball_y, {4{10'd300}});
    chk({tag, "_speed"}, {speed_x, speed_y}, 0);
  endtask

  initial begin
    int   maxv;
    int   d0;
    exp_t e;
    model_reset();
    fork
      forever begin
        @(negedge pixel_clk);
        if (rst_n && done) begin
          n_done++;
          if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("latency", cyc - int'(e.cyc), 13);
            chk("ball_x", ball_x, e.x);
            chk("ball_y", ball_y, e.y);
            chk("speed_x", speed_x, e.vx);
            chk("speed_y", speed_y, e.vy);
          end
        end
      end
    join_none

    // Reset values
    repeat (2) @(negedge pixel_clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // Single idle pass; first read targets ball 0
    tick(0, 0, 0, 0, 0);
    chk("first_rd", coll.coll_rd, 1);
    chk("first_addr", coll.coll_addr, 300 * 800 + 200);
    chk("busy_in_pass", busy, 1);
    wait_quiet();
    chk("b2_x", ball_x[20 +: 10], 280);
    chk("b2_y", ball_y[20 +: 10], 300);
    chk("b2_v", {speed_x[20 +: 10], speed_y[20 +: 10]}, 0);

    // Thrust right on ball 1 for three frames, first one decelerated
    do_reset();
    for (int k = 0; k < 3; k++) frame(1, 0, 1, 0, 0);
    chk("b1_vx", speed_x[10 +: 10], 2);
    chk("b1_x", ball_x[10 +: 10], 241);
    chk("others_x", {ball_x[30 +: 10], ball_x[20 +: 10], ball_x[0 +: 10]}, {10'd320, 10'd280, 10'd200});

    // Build ball 0 up to vx=+5, then reflect off an x wall
    do_reset();
    for (int k = 0; k < 7; k++) frame(0, 0, 1, 0, 0);
    chk("b0_vx_pre", speed_x[0 +: 10], 5);
    chk("b0_x_pre", ball_x[0 +: 10], 214);
    hit_x_addr = 19'(300 * 800 + 214);
    frame(0, 0, 0, 0, 0);
    hit_x_addr = '1;
    chk("b0_vx_refl", $signed(speed_x[0 +: 10]), -5);
    chk("b0_x_refl", ball_x[0 +: 10], 209);

    // Ball 2 moving down, then y wall on a decel frame
    frame(2, 0, 0, 0, 1);
    frame(2, 0, 0, 0, 1);
    hit_y_addr = 19'(301 * 800 + 280);
    frame(0, 0, 0, 0, 0);
    hit_y_addr = '1;
    chk("b2_y_refl", ball_y[20 +: 10], 299);
    chk("b2_vy_refl", $signed(speed_y[20 +: 10]), -1);

    // Cancelling buttons and out-of-range selections
    frame(0, 1, 1, 1, 1);
    frame(5, 0, 1, 0, 1);
    frame(7, 1, 0, 1, 0);
    frame(3, 0, 0, 1, 0);

    // Tick during a pass is dropped and latches overrun
    do_reset();
    d0 = n_done;
    tick(0, 0, 0, 0, 0);
    repeat (3) @(negedge pixel_clk);
    frame_tick = 1'b1;
    @(negedge pixel_clk);
    frame_tick = 1'b0;
    wait_quiet();
    repeat (4) @(negedge pixel_clk);
    chk("overrun_set", overrun, 1);
    chk("single_done", n_done - d0, 1);
`ifdef OVERRUN_CNT_EN
    chk("overrun_cnt", overrun_cnt, 1);
`endif
    frame(0, 0, 0, 0, 0);
    chk("overrun_sticky", overrun, 1);

    // Long thrust: speed and position saturation
    do_reset();
    maxv = 0;
    for (int k = 0; k < 45; k++) begin
      frame(0, 0, 1, 0, 0);
      if ($signed(speed_x[0 +: 10]) > maxv) maxv = $signed(speed_x[0 +: 10]);
      if (k == 29) begin
        chk("vx_sat30", $signed(speed_x[0 +: 10]), 20);
        chk("x_30", ball_x[0 +: 10], 530);
      end
    end
    chk("vx_max", maxv, 20);
    chk("x_sat", ball_x[0 +: 10], 799);

    // Reset in the WAIT state of ball 2 aborts the pass
    do_reset();
    frame(0, 0, 1, 0, 0);
    d0 = n_done;
    tick(0, 0, 1, 0, 0);
    repeat (7) @(posedge pixel_clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    @(negedge pixel_clk);
    check_reset_outputs("abort");
    @(negedge pixel_clk);
    rst_n = 1'b1;
    repeat (20) @(negedge pixel_clk);
    chk("abort_no_done", n_done - d0, 0);
    check_reset_outputs("abort_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
